// File: rtl/spi_fifo_bridge.sv
// Host-side front end for spiUnit: TX/RX FIFOs, transmitReady/idle launch FSM, finalCycle tick.
// Defining SPI_FIFO_BRIDGE_IRQ_EN adds parameter RX_IRQ_LEVEL and a registered irq output.
module spi_fifo_bridge #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned DEPTH     = 8,
`ifdef SPI_FIFO_BRIDGE_IRQ_EN
  parameter int unsigned RX_IRQ_LEVEL = DEPTH / 2,
`endif
  parameter int unsigned DIVWIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DIVWIDTH-1:0]    clockDivider,
  input  logic                   txWrite,
  input  logic [DATAWIDTH-1:0]   txData,
  output logic                   txFull,
  output logic                   txEmpty,
  output logic [$clog2(DEPTH):0] txLevel,
  input  logic                   rxRead,
  output logic [DATAWIDTH-1:0]   rxData,
  output logic                   rxEmpty,
  output logic [$clog2(DEPTH):0] rxLevel,
  output logic                   rxOverflow,
  input  logic                   clearFlags,
  output logic                   finalCycle,
  output logic [DATAWIDTH-1:0]   dataRegIn,
  output logic                   transmitReady,
  input  logic                   idle,
  input  logic                   coreWrite,
`ifdef SPI_FIFO_BRIDGE_IRQ_EN
  output logic                   irq,
`endif
  input  logic [DATAWIDTH-1:0]   dataReg
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Bit-rate divider
  // ---------------------------------------------------------------------------
  logic [DIVWIDTH-1:0] cnt_q, cnt_d;
  logic                final_cycle_q;
  logic                wrap;

  // >= rather than == so a divider lowered below cnt wraps immediately.
  assign wrap  = (cnt_q >= clockDivider);
  assign cnt_d = wrap ? '0 : cnt_q + DIVWIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      final_cycle_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      final_cycle_q <= wrap;
    end
  end

  assign finalCycle = final_cycle_q;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [DATAWIDTH-1:0] tx_mem_q [DEPTH];
  logic [PtrW-1:0]      tx_wptr_q, tx_rptr_q;
  logic [LvlW-1:0]      tx_level_q, tx_level_d;
  logic                 tx_push, tx_pop, tx_full, tx_empty;

  assign tx_full  = (tx_level_q == LvlFull);
  assign tx_empty = (tx_level_q == '0);
  assign tx_push  = txWrite && !tx_full;

  always_comb begin
    tx_level_d = tx_level_q;
    unique case ({tx_push, tx_pop})
      2'b10:   tx_level_d = tx_level_q + LvlW'(1);
      2'b01:   tx_level_d = tx_level_q - LvlW'(1);
      default: tx_level_d = tx_level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_level_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + PtrW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PtrW'(1);
      tx_level_q <= tx_level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && tx_push) tx_mem_q[tx_wptr_q] <= txData;
  end

  assign txFull  = tx_full;
  assign txEmpty = tx_empty;
  assign txLevel = tx_level_q;

  // ---------------------------------------------------------------------------
  // Launch FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {StIdle, StRequest, StBusy} state_e;

  state_e               state_q, state_d;
  logic                 tr_q, tr_d;
  logic [DATAWIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      tr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tr_q    <= tr_d;
      data_q  <= data_d;
    end
  end

  // enable only gates the start; a presented word always completes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (enable && !tx_empty && idle) state_d = StRequest;
      StRequest: if (!idle) state_d = StBusy;
      StBusy:    if (idle) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    tr_d   = (state_d == StRequest);
    data_d = data_q;
    if ((state_q == StIdle) && (state_d == StRequest)) data_d = tx_mem_q[tx_rptr_q];
  end

  assign tx_pop        = (state_q == StRequest) && !idle;
  assign transmitReady = tr_q;
  assign dataRegIn     = data_q;

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [DATAWIDTH-1:0] rx_mem_q [DEPTH];
  logic [PtrW-1:0]      rx_wptr_q, rx_rptr_q;
  logic [LvlW-1:0]      rx_level_q, rx_level_d;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic                 rx_overflow_q, rx_overflow_d, rx_drop;

  assign rx_full  = (rx_level_q == LvlFull);
  assign rx_empty = (rx_level_q == '0);
  assign rx_pop   = rxRead && !rx_empty;
  // A same-cycle read frees the slot, so a full FIFO still accepts the word.
  assign rx_push  = coreWrite && (!rx_full || rxRead);
  assign rx_drop  = coreWrite && rx_full && !rxRead;

  always_comb begin
    rx_level_d = rx_level_q;
    unique case ({rx_push, rx_pop})
      2'b10:   rx_level_d = rx_level_q + LvlW'(1);
      2'b01:   rx_level_d = rx_level_q - LvlW'(1);
      default: rx_level_d = rx_level_q;
    endcase
  end

  always_comb begin
    rx_overflow_d = rx_overflow_q;
    if (clearFlags) rx_overflow_d = 1'b0;
    if (rx_drop)    rx_overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wptr_q     <= '0;
      rx_rptr_q     <= '0;
      rx_level_q    <= '0;
      rx_overflow_q <= 1'b0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + PtrW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PtrW'(1);
      rx_level_q    <= rx_level_d;
      rx_overflow_q <= rx_overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && rx_push) rx_mem_q[rx_wptr_q] <= dataReg;
  end

  assign rxData     = rx_mem_q[rx_rptr_q];
  assign rxEmpty    = rx_empty;
  assign rxLevel    = rx_level_q;
  assign rxOverflow = rx_overflow_q;

`ifdef SPI_FIFO_BRIDGE_IRQ_EN
  // ---------------------------------------------------------------------------
  // Interrupt: RX threshold, RX overflow, or TX queue fully drained
  // ---------------------------------------------------------------------------
  logic irq_q, irq_d;

  assign irq_d = (rx_level_q >= LvlW'(RX_IRQ_LEVEL)) | rx_overflow_q |
                 (tx_empty & (state_q == StIdle) & idle);

  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: doc/spi_fifo_bridge.md
Name: spi_fifo_bridge

Overview:
Host-side front end for spiUnit (DATAWIDTH=8 default). Buffers outgoing words in a TX FIFO and launches them into spiUnit with the transmitReady/idle handshake. Captures received words into an RX FIFO on coreWrite. Generates the finalCycle bit-rate tick that paces spiUnit.

Parameters:
DATAWIDTH, 8, word width; must match spiUnit DATAWIDTH
DEPTH, 8, entries per FIFO; power of two, >= 2
DIVWIDTH, 16, width of the clockDivider input

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = launch TX words; 0 = hold the TX FIFO (RX capture and divider keep running)
clockDivider  input  DIVWIDTH  finalCycle period minus 1, in clk cycles
txWrite  input  1  push txData into the TX FIFO
txData  input  DATAWIDTH  word to transmit
txFull  output  1  TX FIFO full
txEmpty  output  1  TX FIFO empty
txLevel  output  $clog2(DEPTH)+1  TX occupancy
rxRead  input  1  pop the RX FIFO
rxData  output  DATAWIDTH  RX FIFO head (show-ahead); valid when rxEmpty=0
rxEmpty  output  1  RX FIFO empty
rxLevel  output  $clog2(DEPTH)+1  RX occupancy
rxOverflow  output  1  sticky: a received word was dropped
clearFlags  input  1  clears rxOverflow
finalCycle  output  1  one-clk tick to spiUnit
dataRegIn  output  DATAWIDTH  word presented to spiUnit
transmitReady  output  1  launch request to spiUnit
idle  input  1  spiUnit idle
coreWrite  input  1  spiUnit pulse: received word valid on dataReg
dataReg  input  DATAWIDTH  spiUnit received word

Behaviour:
- Reset values (all outputs registered or derived from registers):
  - finalCycle=0, transmitReady=0, dataRegIn=0, rxOverflow=0.
  - txFull=0, txEmpty=1, rxEmpty=1, txLevel=0, rxLevel=0.
  - FIFO pointers 0; FSM enters IDLE. Memory contents are not reset.
- Reset mid-transfer: flushes both FIFOs and returns the FSM to IDLE in the same edge. spiUnit shares the same reset.
- Divider:
  - Counter cnt increments each clk. When cnt==clockDivider, cnt wraps to 0 and finalCycle=1 for the next cycle.
  - Period is clockDivider+1 cycles; clockDivider=0 gives finalCycle=1 every cycle.
  - A clockDivider change below the current cnt forces a wrap on the next clk (compare is cnt>=clockDivider).
- Launch FSM:
  - IDLE: if enable && !txEmpty && idle, go to REQUEST. On entry, dataRegIn<=TX head and transmitReady<=1.
  - REQUEST: hold transmitReady=1 and dataRegIn stable until idle=0 is sampled. On that edge: transmitReady<=0, pop the TX FIFO, go to BUSY.
  - BUSY: wait for idle=1, then go to IDLE.
  - Minimum of one cycle in IDLE between words.
  - enable falling in REQUEST does not abort the request: the word is committed once presented.
- TX FIFO:
  - txWrite when txFull: write ignored, no state change.
  - Push and pop in the same cycle: level unchanged.
  - A push into an empty FIFO is visible to the FSM the next cycle.
- RX FIFO:
  - coreWrite pushes dataReg.
  - rxRead when rxEmpty: ignored.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - coreWrite when full with no rxRead: word dropped, rxOverflow<=1.
  - clearFlags with a simultaneous overflow event: set wins.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Level is a separate counter with full = (level==DEPTH).

Optional Feature:
SPI_FIFO_BRIDGE_IRQ_EN
- Defined:
  - Adds parameter RX_IRQ_LEVEL (default DEPTH/2) and output irq (1 bit, reset 0).
  - irq is registered: irq <= (rxLevel>=RX_IRQ_LEVEL) | rxOverflow | (txEmpty & FSM in IDLE & idle), i.e. the TX queue has fully drained.
- Not defined: no irq port and no RX_IRQ_LEVEL parameter; all other behaviour is identical.

Test Plan:
- Reset:
  - Stimulus: assert reset 10 cycles mid-transfer with 3 TX words queued.
  - Required response: next cycle txEmpty=1, rxEmpty=1, txLevel=0, rxLevel=0, transmitReady=0, finalCycle=0.
- Divider:
  - Stimulus: clockDivider=10.
  - Required response: finalCycle pulses exactly every 11 clks, one cycle wide. With clockDivider=0, finalCycle=1 continuously.
- Loopback:
  - Stimulus: spiUnit instance with miso=mosi; push 0xAA, 0x55, 0x3C with enable=1.
  - Required response: the three words appear in order on dataRegIn with transmitReady, each held until idle falls; rxData pops 0xAA, 0x55, 0x3C; rxOverflow=0. Repeat for all 8 clockPolarity/clockPhase/dataDirection combinations.
- TX full:
  - Stimulus: enable=0; push 9 words 0x00..0x08 with DEPTH=8.
  - Required response: txFull=1 after 8 pushes, 9th ignored, txLevel=8. Then enable=1: exactly 0x00..0x07 are transmitted.
- RX overflow:
  - Stimulus: pulse coreWrite 9 times with dataReg=0x10..0x18, no rxRead.
  - Required response: rxLevel=8, rxOverflow=1, head=0x10; 0x18 dropped. clearFlags pulse gives rxOverflow=0. Same-cycle coreWrite+rxRead at full gives level 8, no overflow.
- Enable gating:
  - Stimulus: deassert enable while in REQUEST.
  - Required response: the in-flight word completes; no further transmitReady until enable=1.
